// File: rtl/fm_mod_if.sv
// Audio-in / I-Q-out FIFO handshake bundle for the FM modulator.
interface fm_mod_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] audio;
  logic                         empty_audio;
  logic                         rd_en_audio;
  logic signed [DATA_WIDTH-1:0] i_out;
  logic signed [DATA_WIDTH-1:0] q_out;
  logic                         full_i;
  logic                         full_q;
  logic                         wr_en_i;
  logic                         wr_en_q;

  modport master (
    input  audio, empty_audio, full_i, full_q,
    output rd_en_audio, i_out, q_out, wr_en_i, wr_en_q
  );

  modport slave (
    output audio, empty_audio, full_i, full_q,
    input  rd_en_audio, i_out, q_out, wr_en_i, wr_en_q
  );
endinterface

// File: rtl/fm_mod.sv
// FM modulator: integrates Q10 audio into a wrapped phase, iterative CORDIC to cos/sin.
// Optional FM_MOD_SAT_EN clamps audio to +/-1.0 before the deviation multiply.
module fm_mod #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int          KF           = 1382,
  parameter int unsigned CORDIC_ITERS = 10
) (
  input logic      clk,
  input logic      rst,
  fm_mod_if.master bus
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam logic signed [DW-1:0] KF_W     = DW'(KF);
  localparam logic signed [DW-1:0] PI       = DW'(3217);
  localparam logic signed [DW-1:0] NEG_PI   = DW'(-3217);
  localparam logic signed [DW-1:0] TWO_PI   = DW'(6434);
  localparam logic signed [DW-1:0] HALF_PI  = DW'(1608);
  localparam logic signed [DW-1:0] NEG_HPI  = DW'(-1608);
  localparam logic signed [DW-1:0] X0       = DW'(622);
  localparam logic signed [DW-1:0] SAT_POS  = DW'(1024);
  localparam logic signed [DW-1:0] SAT_NEG  = DW'(-1024);
  localparam logic [3:0]           LAST_K   = 4'(CORDIC_ITERS - 1);

  typedef enum logic [1:0] {S_READ, S_ACCUM, S_ROTATE, S_WRITE} state_e;

  state_e                state_q, state_d;
  logic signed [DW-1:0]  phase_q, phase_d;
  logic signed [DW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic                  neg_q, neg_d;
  logic [3:0]            k_q, k_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic signed [DW-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;

  logic signed [DW-1:0]  audio_sel, prod, inc, x_sh, y_sh, atan_k;

  function automatic logic signed [DW-1:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    atan_lut = DW'(804);
      4'd1:    atan_lut = DW'(475);
      4'd2:    atan_lut = DW'(251);
      4'd3:    atan_lut = DW'(127);
      4'd4:    atan_lut = DW'(64);
      4'd5:    atan_lut = DW'(32);
      4'd6:    atan_lut = DW'(16);
      4'd7:    atan_lut = DW'(8);
      4'd8:    atan_lut = DW'(4);
      4'd9:    atan_lut = DW'(2);
      default: atan_lut = DW'(0);
    endcase
  endfunction

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    neg_d     = neg_q;
    k_d       = k_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    i_out_d   = i_out_q;
    q_out_d   = q_out_q;

`ifdef FM_MOD_SAT_EN
    if (bus.audio > SAT_POS)      audio_sel = SAT_POS;
    else if (bus.audio < SAT_NEG) audio_sel = SAT_NEG;
    else                          audio_sel = bus.audio;
`else
    audio_sel = bus.audio;
`endif
    // Product wraps at DW bits when unclamped.
    prod   = KF_W * audio_sel;
    inc    = prod >>> 10;
    x_sh   = x_q >>> k_q;
    y_sh   = y_q >>> k_q;
    atan_k = atan_lut(k_q);

    case (state_q)
      S_READ: begin
        if (!bus.empty_audio) begin
          rd_en_d = 1'b1;
          phase_d = phase_q + inc;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (phase_q >= PI) begin
          phase_d = phase_q - TWO_PI;
        end else if (phase_q < NEG_PI) begin
          phase_d = phase_q + TWO_PI;
        end else begin
          // Fold into +/-pi/2 so the CORDIC converges; sign restored on output.
          x_d = X0;
          y_d = '0;
          k_d = 4'd0;
          if (phase_q > HALF_PI) begin
            z_d   = phase_q - PI;
            neg_d = 1'b1;
          end else if (phase_q < NEG_HPI) begin
            z_d   = phase_q + PI;
            neg_d = 1'b1;
          end else begin
            z_d   = phase_q;
            neg_d = 1'b0;
          end
          state_d = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (!z_q[DW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_k;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_k;
        end
        k_d = k_q + 4'd1;
        if (k_q == LAST_K) begin
          i_out_d = neg_q ? -x_d : x_d;
          q_out_d = neg_q ? -y_d : y_d;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!bus.full_i && !bus.full_q) begin
          wr_en_d = 1'b1;
          state_d = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_READ;
      phase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      k_q     <= 4'd0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      i_out_q <= '0;
      q_out_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      k_q     <= k_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      i_out_q <= i_out_d;
      q_out_q <= q_out_d;
    end
  end

  assign bus.rd_en_audio = rd_en_q;
  assign bus.wr_en_i     = wr_en_q;
  assign bus.wr_en_q     = wr_en_q;
  assign bus.i_out       = i_out_q;
  assign bus.q_out       = q_out_q;
endmodule
